mem_port_arbiter: RTL and testbench

Shares one single-ported memory bus between the core's instruction-fetch requester and its load/store requester. The core stalls on the returned grant/valid strobes. Requests are latched, one transaction is outstanding at a time, and a response watchdog runs on every transaction. It sits between the core's fetch/LSU bus masters and the memory or interconnect slave port.

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between the fetch (I) and load/store (D) masters.
// Ties go to D; define MEM_ARB_RR_EN to break ties round-robin instead.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy,
  output logic                err
);
  localparam int STRB_W = DATA_W/8;
  localparam int CNT_W  = $clog2(TIMEOUT+1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic {OWN_I, OWN_D} own_t;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mreq_t;

  state_t           state;
  own_t             owner;
  mreq_t            lat;
  logic [CNT_W-1:0] cnt;

  mreq_t i_fields, d_fields;
  logic  any_req, pick_d;
  logic  timeout, gnt_fire, abort_req, rv_fire;
  logic  [DATA_W-1:0] rdata;

  assign any_req  = i_req | d_req;
  assign i_fields = '{we: 1'b0, addr: i_addr, wdata: '0, wstrb: '0};
  assign d_fields = '{we: d_we, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb};

`ifdef MEM_ARB_RR_EN
  own_t last_owner;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    pick_d = d_req;
    if (i_req && d_req) pick_d = (last_owner == OWN_I);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                      last_owner <= OWN_D;
    else if (state == IDLE && any_req) last_owner <= pick_d ? OWN_D : OWN_I;
  end
`else
  assign pick_d = d_req;
`endif

  // Watchdog expiry completes the transaction towards the owner so the core never hangs.
  assign timeout   = (cnt == TMO);
  assign gnt_fire  = (state == REQ) && (m_gnt || timeout);
  assign abort_req = (state == REQ) && !m_gnt && timeout;
  assign rv_fire   = ((state == WAIT) && (m_rvalid || timeout)) || (abort_req && !lat.we);
  assign rdata     = ((state == WAIT) && m_rvalid) ? m_rdata : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= OWN_I;
      lat   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          state <= REQ;
          cnt   <= '0;
          owner <= pick_d ? OWN_D : OWN_I;
          lat   <= pick_d ? d_fields : i_fields;
        end
        REQ: begin
          if (m_gnt) begin
            state <= lat.we ? IDLE : WAIT;
            cnt   <= '0;
          end else if (timeout) begin
            state <= IDLE;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (m_rvalid) begin
            state <= IDLE;
          end else if (timeout) begin
            state <= IDLE;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign m_req   = (state == REQ);
  assign m_we    = lat.we;
  assign m_addr  = lat.addr;
  assign m_wdata = lat.wdata;
  assign m_wstrb = lat.wstrb;

  assign i_gnt    = gnt_fire && (owner == OWN_I);
  assign d_gnt    = gnt_fire && (owner == OWN_D);
  assign i_rvalid = rv_fire && (owner == OWN_I);
  assign d_rvalid = rv_fire && (owner == OWN_D);
  assign i_rdata  = i_rvalid ? rdata : '0;
  assign d_rdata  = d_rvalid ? rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner cases and a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        m_gnt = 1'b0, m_rvalid = 1'b0;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, busy, err;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_wstrb;

  int n_chk = 0;
  int n_fail = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got hang, expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 3 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    m_gnt = 0; m_rvalid = 0; m_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    step();
    step();
    #3;
    chk("rst_m_req", m_req, 0);     chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);   chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_wstrb", m_wstrb, 0); chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);     chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0); chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0); chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_n = 1;
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic ir; logic [31:0] ia;
    logic dr, dw; logic [31:0] da, dwd; logic [3:0] ds;
    logic mg, mrv; logic [31:0] mrd;
    logic e_mreq, e_mwe; logic [31:0] e_maddr, e_mwdata;
    logic e_ig, e_dg, e_irv; logic [31:0] e_ird;
    logic e_drv; logic [31:0] e_drd; logic e_busy;
  } vec_t;

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia,
    input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
    input logic [3:0] ds, input logic mg, input logic mrv, input logic [31:0] mrd,
    input logic e_mreq, input logic e_mwe, input logic [31:0] e_maddr,
    input logic [31:0] e_mwdata, input logic e_ig, input logic e_dg, input logic e_irv,
    input logic [31:0] e_ird, input logic e_drv, input logic [31:0] e_drd,
    input logic e_busy);
    vec_t v;
    v = '{ir, ia, dr, dw, da, dwd, ds, mg, mrv, mrd,
          e_mreq, e_mwe, e_maddr, e_mwdata, e_ig, e_dg, e_irv, e_ird, e_drv, e_drd, e_busy};
    return v;
  endfunction

  task automatic run_table();
    vec_t tbl[$];
    //            ir ia       dr dw da       dwd           ds   mg mrv mrd            mreq mwe maddr   mwdata       ig dg irv ird   drv drd           busy
    tbl.push_back(mk(0, 0,      0, 0, 0,       0,            0,   0, 0, 0,            0, 0, 0,       0,           0, 0, 0, 0,     0, 0,            0));
    tbl.push_back(mk(0, 0,      0, 0, 0,       0,            0,   0, 1, 32'hBAD,      0, 0, 0,       0,           0, 0, 0, 0,     0, 0,            0));
    tbl.push_back(mk(1, 'h100,  0, 0, 0,       0,            0,   1, 0, 0,            0, 0, 0,       0,           0, 0, 0, 0,     0, 0,            0));
    tbl.push_back(mk(1, 'h100,  0, 0, 0,       0,            0,   1, 0, 0,            1, 0, 'h100,   0,           1, 0, 0, 0,     0, 0,            1));
    tbl.push_back(mk(0, 0,      0, 0, 0,       0,            0,   1, 1, 32'h13,       0, 0, 0,       0,           0, 0, 1, 'h13,  0, 0,            1));
    tbl.push_back(mk(0, 0,      0, 0, 0,       0,            0,   0, 0, 0,            0, 0, 0,       0,           0, 0, 0, 0,     0, 0,            0));
    tbl.push_back(mk(0, 0,      1, 1, 'h2000,  'hDEADBEEF,   'hF, 1, 0, 0,            0, 0, 0,       0,           0, 0, 0, 0,     0, 0,            0));
    tbl.push_back(mk(0, 0,      1, 1, 'h2000,  'hDEADBEEF,   'hF, 1, 0, 0,            1, 1, 'h2000,  'hDEADBEEF,  0, 1, 0, 0,     0, 0,            1));
    tbl.push_back(mk(0, 0,      0, 0, 0,       0,            0,   0, 1, 32'h5555,     0, 0, 0,       0,           0, 0, 0, 0,     0, 0,            0));
    tbl.push_back(mk(0, 0,      1, 0, 'h44,    0,            0,   0, 0, 0,            0, 0, 0,       0,           0, 0, 0, 0,     0, 0,            0));
    tbl.push_back(mk(0, 0,      1, 0, 'h44,    0,            0,   0, 1, 32'h77,       1, 0, 'h44,    0,           0, 0, 0, 0,     0, 0,            1));
    tbl.push_back(mk(0, 0,      1, 0, 'h44,    0,            0,   1, 0, 0,            1, 0, 'h44,    0,           0, 1, 0, 0,     0, 0,            1));
    tbl.push_back(mk(0, 0,      0, 0, 0,       0,            0,   0, 1, 32'hCAFE0001, 0, 0, 0,       0,           0, 0, 0, 0,     1, 32'hCAFE0001, 1));
    tbl.push_back(mk(0, 0,      0, 0, 0,       0,            0,   0, 0, 0,            0, 0, 0,       0,           0, 0, 0, 0,     0, 0,            0));
    foreach (tbl[k]) begin
      step();
      i_req = tbl[k].ir; i_addr = tbl[k].ia;
      d_req = tbl[k].dr; d_we = tbl[k].dw; d_addr = tbl[k].da;
      d_wdata = tbl[k].dwd; d_wstrb = tbl[k].ds;
      m_gnt = tbl[k].mg; m_rvalid = tbl[k].mrv; m_rdata = tbl[k].mrd;
      #3;
      chk($sformatf("vec%0d_m_req", k), m_req, tbl[k].e_mreq);
      chk($sformatf("vec%0d_busy", k), busy, tbl[k].e_busy);
      chk($sformatf("vec%0d_i_gnt", k), i_gnt, tbl[k].e_ig);
      chk($sformatf("vec%0d_d_gnt", k), d_gnt, tbl[k].e_dg);
      chk($sformatf("vec%0d_i_rvalid", k), i_rvalid, tbl[k].e_irv);
      chk($sformatf("vec%0d_i_rdata", k), i_rdata, tbl[k].e_ird);
      chk($sformatf("vec%0d_d_rvalid", k), d_rvalid, tbl[k].e_drv);
      chk($sformatf("vec%0d_d_rdata", k), d_rdata, tbl[k].e_drd);
      if (tbl[k].e_mreq) begin
        chk($sformatf("vec%0d_m_addr", k), m_addr, tbl[k].e_maddr);
        chk($sformatf("vec%0d_m_we", k), m_we, tbl[k].e_mwe);
        if (tbl[k].e_mwe) chk($sformatf("vec%0d_m_wdata", k), m_wdata, tbl[k].e_mwdata);
      end
    end
    clear_inputs();
  endtask

  // ---------------- directed multi-cycle sequences ----------------
  task automatic run_tie();
    logic [3:0] order, exp_order;
    int ng;
    logic gi, gd;
`ifdef MEM_ARB_RR_EN
    exp_order = 4'b1010;  // bit n = 1 means grant n went to D: I, D, I, D
`else
    exp_order = 4'b0101;  // D, I, D, I
`endif
    order = '0;
    ng = 0;
    do_reset();
    step();
    m_gnt = 1; m_rvalid = 1; m_rdata = 32'h13;
    i_addr = 32'h300; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    i_req = 1; d_req = 1;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #3;
      chk("tie_single_gnt", i_gnt & d_gnt, 0);
      chk("tie_no_d_rvalid", d_rvalid, 0);
      if (i_rvalid) chk("tie_i_rdata", i_rdata, 32'h13);
      if (i_gnt || d_gnt) begin
        order[ng] = d_gnt;
        ng++;
      end
      gi = i_gnt; gd = d_gnt;
      step();
      i_req = !gi; d_req = !gd;
    end
    chk("tie_grant_count", ng, 4);
    chk("tie_grant_order", order, exp_order);
    clear_inputs();
    step(); step(); step();
  endtask

  task automatic run_stall();
    int ngnt;
    ngnt = 0;
    step();
    d_req = 1; d_we = 0; d_addr = 32'h55;
    #3;
    for (int s = 0; s < 3; s++) begin
      step();
      #3;
      chk("stall_m_req", m_req, 1);
      chk("stall_m_addr", m_addr, 32'h55);
      chk("stall_m_we", m_we, 0);
      ngnt += int'(d_gnt);
    end
    step();
    m_gnt = 1;
    #3;
    chk("stall_m_addr_at_gnt", m_addr, 32'h55);
    ngnt += int'(d_gnt);
    step();
    d_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'hABCD;
    #3;
    ngnt += int'(d_gnt);
    chk("stall_d_gnt_count", ngnt, 1);
    chk("stall_d_rvalid", d_rvalid, 1);
    chk("stall_d_rdata", d_rdata, 32'hABCD);
    step();
    m_rvalid = 0;
    #3;
    chk("stall_idle_busy", busy, 0);
  endtask

  task automatic run_watchdog();
    // Read granted, data never returns: abort in the 5th WAIT cycle.
    step();
    d_req = 1; d_we = 0; d_addr = 32'h77; m_gnt = 1;
    #3;
    step();
    #3;
    chk("wd_d_gnt", d_gnt, 1);
    step();
    d_req = 0; m_gnt = 0; m_rdata = 32'hFFFFFFFF;
    for (int w = 1; w <= 5; w++) begin
      if (w > 1) step();
      #3;
      chk($sformatf("wd_wait%0d_d_rvalid", w), d_rvalid, (w == 5));
      chk($sformatf("wd_wait%0d_d_rdata", w), d_rdata, 0);
    end
    step();
    #3;
    chk("wd_err_set", err, 1);
    chk("wd_busy_after", busy, 0);
    // Fetch never granted: abort in the 5th REQ cycle with gnt and zero read data.
    i_req = 1; i_addr = 32'h88;
    #0;
    for (int w = 1; w <= 5; w++) begin
      step();
      #3;
      chk($sformatf("wd_req%0d_i_gnt", w), i_gnt, (w == 5));
      chk($sformatf("wd_req%0d_i_rvalid", w), i_rvalid, (w == 5));
      chk($sformatf("wd_req%0d_i_rdata", w), i_rdata, 0);
    end
    step();
    i_req = 0;
    #3;
    chk("wd_req_abort_idle", busy, 0);
    // Next transaction behaves normally; err stays set.
    step();
    i_req = 1; i_addr = 32'h100; m_gnt = 1;
    #3;
    step();
    #3;
    chk("wd_next_i_gnt", i_gnt, 1);
    chk("wd_next_m_addr", m_addr, 32'h100);
    step();
    i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h13;
    #3;
    chk("wd_next_i_rvalid", i_rvalid, 1);
    chk("wd_next_i_rdata", i_rdata, 32'h13);
    chk("wd_err_sticky", err, 1);
    step();
    m_rvalid = 0;
  endtask

  task automatic run_reset_in_wait();
    step();
    i_req = 1; i_addr = 32'h120; m_gnt = 1;
    #3;
    step();
    #3;
    chk("rw_i_gnt", i_gnt, 1);
    step();
    i_req = 0; m_gnt = 0;
    #3;
    chk("rw_in_wait", busy, 1);
    step();
    rst_n = 0;
    #3;
    step();
    rst_n = 1; m_rvalid = 1; m_rdata = 32'h99;
    #3;
    chk("rw_i_rvalid", i_rvalid, 0);
    chk("rw_d_rvalid", d_rvalid, 0);
    chk("rw_i_rdata", i_rdata, 0);
    chk("rw_busy", busy, 0);
    chk("rw_m_req", m_req, 0);
    chk("rw_m_addr", m_addr, 0);
    chk("rw_err_cleared", err, 0);
    step();
    m_rvalid = 0;
  endtask

  // ---------------- randomized run vs transaction model ----------------
  function automatic bit winner_is_d(input bit ir, input bit dr, input bit last_d);
`ifdef MEM_ARB_RR_EN
    if (ir && dr) return !last_d;
`endif
    if (last_d && !last_d) return 1'b0;
    return dr;
  endfunction

  task automatic run_random(input int ncyc);
    bit act, granted, own_d, last_d, ip, dp, dwe, t_we;
    bit e_mreq, e_ig, e_dg, e_irv, e_drv;
    logic [31:0] ia, da, dwd, t_addr, t_wdata;
    logic [3:0]  dws, t_wstrb;
    int icool, dcool, gwait, rwait, ntx;
    act = 0; granted = 0; own_d = 0; last_d = 1; t_we = 0;
    ip = 0; dp = 0; dwe = 0; ia = '0; da = '0; dwd = '0; dws = '0;
    t_addr = '0; t_wdata = '0; t_wstrb = '0;
    icool = 0; dcool = 0; gwait = 0; rwait = 0; ntx = 0;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      step();
      i_req = ip; i_addr = ia;
      d_req = dp; d_we = dwe; d_addr = da; d_wdata = dwd; d_wstrb = dws;
      m_gnt = act && !granted && (gwait == 0);
      m_rvalid = (act && granted) ? (rwait == 0) : ($urandom_range(0, 3) == 0);
      m_rdata = $urandom();
      #3;
      e_mreq = act && !granted;
      e_ig   = e_mreq && m_gnt && !own_d;
      e_dg   = e_mreq && m_gnt && own_d;
      e_irv  = act && granted && m_rvalid && !own_d;
      e_drv  = act && granted && m_rvalid && own_d;
      chk("rnd_m_req", m_req, e_mreq);
      chk("rnd_busy", busy, act);
      chk("rnd_i_gnt", i_gnt, e_ig);
      chk("rnd_d_gnt", d_gnt, e_dg);
      chk("rnd_i_rvalid", i_rvalid, e_irv);
      chk("rnd_d_rvalid", d_rvalid, e_drv);
      chk("rnd_i_rdata", i_rdata, e_irv ? m_rdata : 32'h0);
      chk("rnd_d_rdata", d_rdata, e_drv ? m_rdata : 32'h0);
      if (e_mreq) begin
        chk("rnd_m_addr", m_addr, t_addr);
        chk("rnd_m_we", m_we, t_we);
        if (t_we) begin
          chk("rnd_m_wdata", m_wdata, t_wdata);
          chk("rnd_m_wstrb", m_wstrb, t_wstrb);
        end
      end
      // Transaction model: one outstanding access, completes on grant (write) or data (read).
      if (!act) begin
        if (ip || dp) begin
          own_d = winner_is_d(ip, dp, last_d);
          last_d = own_d;
          act = 1; granted = 0;
          t_we = own_d ? dwe : 1'b0;
          t_addr = own_d ? da : ia;
          t_wdata = dwd; t_wstrb = dws;
          gwait = $urandom_range(0, 3);
        end
      end else if (!granted) begin
        if (m_gnt) begin
          ntx++;
          if (t_we) act = 0;
          else begin granted = 1; rwait = $urandom_range(0, 2); end
        end else gwait--;
      end else begin
        if (m_rvalid) act = 0;
        else rwait--;
      end
      // Requesters: hold until granted, then stay low at least one cycle.
      if (e_ig) begin ip = 0; icool = $urandom_range(1, 3); end
      else if (!ip) begin
        if (icool > 0) icool--;
        else if ($urandom_range(0, 1) == 1) begin ip = 1; ia = $urandom(); end
      end
      if (e_dg) begin dp = 0; dcool = $urandom_range(1, 3); end
      else if (!dp) begin
        if (dcool > 0) dcool--;
        else if ($urandom_range(0, 1) == 1) begin
          dp = 1; dwe = $urandom_range(0, 1); da = $urandom(); dwd = $urandom();
          dws = 4'($urandom_range(0, 15));
        end
      end
    end
    #3;
    chk("rnd_err_clear", err, 0);
    if (ntx < 100) chk("rnd_txn_progress", ntx, 100);
    clear_inputs();
  endtask

  initial begin
    do_reset();
    run_table();
    run_stall();
    run_watchdog();
    run_reset_in_wait();
    run_tie();
    run_random(3000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
